// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, FSM encoding and GF(2^8) helpers built from xtime.
package aes_pkg;

    localparam int unsigned AES_NB  = 4;
    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8); zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int unsigned c = 0; c < AES_NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[BLOCK_W-1-8*(r+4*c) -: 8] = s[BLOCK_W-1-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_core_if.sv
// Ciphertext-in / plaintext-out valid-ready bus of the inverse-cipher core.
interface aes_inv_cipher_core_if import aes_pkg::*;;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] ct_in;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] pt_out;

    modport master (
        output in_valid, ct_in, out_ready,
        input  in_ready, out_valid, pt_out
    );

    modport slave (
        input  in_valid, ct_in, out_ready,
        output in_ready, out_valid, pt_out
    );
endinterface

// File: rtl/aes_inv_mix_columns.sv
// Combinational InvMixColumns over all four columns of the state.
module aes_inv_mix_columns import aes_pkg::*; (
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);

    for (genvar c = 0; c < AES_NB; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[BLOCK_W-1-32*c      -: 8];
        assign a1 = din[BLOCK_W-1-32*c-8    -: 8];
        assign a2 = din[BLOCK_W-1-32*c-16   -: 8];
        assign a3 = din[BLOCK_W-1-32*c-24   -: 8];

        assign dout[BLOCK_W-1-32*c    -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        assign dout[BLOCK_W-1-32*c-8  -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        assign dout[BLOCK_W-1-32*c-16 -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
        assign dout[BLOCK_W-1-32*c-24 -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// 16-byte InvSubBytes: inverse affine transform followed by GF(2^8) inversion per byte.
module aes_inv_sub_bytes import aes_pkg::*; (
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    for (genvar i = 0; i < BLOCK_W / 8; i++) begin : g_byte
        assign dout[8*i +: 8] = inv_sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched by index.
module aes_inv_cipher_core import aes_pkg::*; #(
    parameter int unsigned NR       = 10,
    parameter int unsigned RK_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_inv_cipher_core_if.slave  bus,
    output logic [RK_IDX_W-1:0]   rk_idx,
    input  logic [BLOCK_W-1:0]    rk,
    output logic                  busy
);

    fsm_t                fsm;
    logic [BLOCK_W-1:0]  state_q;
    logic [RK_IDX_W-1:0] round_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [BLOCK_W-1:0]  sr, sb, ark, mc;

    assign sr  = inv_shift_rows(state_q);
    assign ark = sb ^ rk;

    aes_inv_sub_bytes u_sub_bytes (
        .din  (sr),
        .dout (sb)
    );

    aes_inv_mix_columns u_mix_columns (
        .din  (ark),
        .dout (mc)
    );

    always_comb begin
        rk_idx = RK_IDX_W'(NR);
        case (fsm)
            S_IDLE:  rk_idx = RK_IDX_W'(NR);
            S_ROUND: rk_idx = round_q;
            default: rk_idx = '0;
        endcase
    end

    // Handshake flags are registered next to the state so they change only on edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            state_q     <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        state_q    <= bus.ct_in ^ rk;
                        round_q    <= RK_IDX_W'(NR - 1);
                        fsm        <= S_ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    state_q <= mc;
                    if (round_q == RK_IDX_W'(1)) begin
                        fsm <= S_FINAL;
                    end else begin
                        round_q <= round_q - RK_IDX_W'(1);
                    end
                end
                S_FINAL: begin
                    state_q     <= ark;
                    fsm         <= S_DONE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        fsm         <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pt_out    = state_q;
    assign busy          = busy_q;

endmodule
